reg_write_arbiter: RTL and testbench

Shares one write path into a bank of 16-bit enable-gated registers among several requesters, such as ALU writeback, memory load and PC save. Each cycle it picks one requester round-robin and returns a one-cycle grant. It then drives a one-hot register enable and the 16-bit write data so exactly one register captures per write. It sits between the execute/memory stages and the register bank; register outputs bypass it.

---
 rtl/reg_write_arbiter.sv | 129 ++++++++++++
 tb/tb_reg_write_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter
// Purpose  : Round-robin arbiter sharing one write path into a bank of
//            16-bit enable-gated registers. A winning requester receives a
//            one-cycle grant while a one-hot register enable and the write
//            data are driven to the bank.
// Options  : REGARB_ZERO_LOCK_EN - when defined, register 0 is read-only.
//            Writes to address 0 are still granted, but no enable is raised.
// Revision : 1.0 - initial release
// ============================================================================
module reg_write_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ*AW-1:0]   REQ_ADDR,
  input  logic [NREQ*16-1:0]   REQ_DATA,
  output logic [NREQ-1:0]      GNT,
  output logic [(2**AW)-1:0]   REG_EN,
  output logic [15:0]          REG_D,
  output logic                 BUSY
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NREG = 2**AW;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic [NREG-1:0] en_nxt;
  logic [15:0]     d_nxt;
  logic            busy_nxt;

  logic            found;
  logic [PW-1:0]   winner;
  logic [AW-1:0]   win_addr;
  logic [15:0]     win_data;
  logic [NREG-1:0] win_en;
  int              cand;

  // Round-robin search: first asserted request starting at ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!found && REQ[cand]) begin
        found  = 1'b1;
        winner = PW'(cand);
      end
    end
  end

  // Winner's target address/data and the one-hot enable it produces.
  always_comb begin
    win_addr = REQ_ADDR[int'(winner)*AW +: AW];
    win_data = REQ_DATA[int'(winner)*16 +: 16];
`ifdef REGARB_ZERO_LOCK_EN
    // Register 0 is read-only: the write is granted but never enabled.
    win_en   = (win_addr == '0) ? '0 : (NREG'(1) << win_addr);
`else
    win_en   = NREG'(1) << win_addr;
`endif
  end

  // Next-state and next-output decode; every output is zero outside WRITE.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = '0;
    en_nxt    = '0;
    d_nxt     = '0;
    busy_nxt  = 1'b0;
    case (state)
      ARB: begin
        if (found) begin
          state_nxt = WRITE;
          gnt_nxt   = NREQ'(1) << winner;
          en_nxt    = win_en;
          d_nxt     = win_data;
          busy_nxt  = 1'b1;
          ptr_nxt   = (int'(winner) == NREQ - 1) ? '0 : PW'(int'(winner) + 1);
        end
      end
      WRITE: begin
        // Single-cycle write; requests are ignored until back in ARB.
        state_nxt = ARB;
      end
      default: begin
        state_nxt = ARB;
      end
    endcase
  end

  // State, pointer and registered outputs; reset also suppresses any grant.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ARB;
      ptr    <= '0;
      GNT    <= '0;
      REG_EN <= '0;
      REG_D  <= '0;
      BUSY   <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      GNT    <= gnt_nxt;
      REG_EN <= en_nxt;
      REG_D  <= d_nxt;
      BUSY   <= busy_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_write_arbiter
// Purpose  : Self-checking bench for reg_write_arbiter. A behavioural model
//            (pending-request list, round-robin pointer, register bank copy)
//            predicts every output each cycle. Honours REGARB_ZERO_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 3;
  localparam int NREG = 8;
`ifdef REGARB_ZERO_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic                CLK = 1'b0;
  logic                RST;
  logic [NREQ-1:0]     REQ;
  logic [NREQ*AW-1:0]  REQ_ADDR;
  logic [NREQ*16-1:0]  REQ_DATA;
  logic [NREQ-1:0]     GNT;
  logic [NREG-1:0]     REG_EN;
  logic [15:0]         REG_D;
  logic                BUSY;

  reg_write_arbiter #(.NREQ(NREQ), .AW(AW)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .REQ      (REQ),
    .REQ_ADDR (REQ_ADDR),
    .REQ_DATA (REQ_DATA),
    .GNT      (GNT),
    .REG_EN   (REG_EN),
    .REG_D    (REG_D),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  // Register bank fed by the arbiter outputs.
  logic [15:0] bank [NREG] = '{default: 16'h0};
  always @(posedge CLK) begin
    for (int a = 0; a < NREG; a++) begin
      if (REG_EN[a]) bank[a] <= REG_D;
    end
  end

  int total = 0;
  int bad   = 0;

  // Requester and model state.
  bit          pend  [NREQ];
  logic [AW-1:0] paddr [NREQ];
  logic [15:0] pdata [NREQ];
  int          cool  [NREQ];
  bit          auto_rereq;
  int          mptr;
  bit          mbusy;
  logic [NREQ-1:0] e_gnt;
  logic [NREG-1:0] e_en;
  logic [15:0]     e_d;
  logic [15:0]     mbank [NREG] = '{default: 16'h0};
  logic [NREQ-1:0] prev_gnt;
  int          order [$];
  logic [15:0] saved;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic raise(input int i, input logic [AW-1:0] a, input logic [15:0] d);
    pend[i]  = 1'b1;
    paddr[i] = a;
    pdata[i] = d;
  endtask

  // One clock: drive inputs, predict the edge, then check at the falling edge.
  task automatic tick(input bit rst_v);
    int w;
    int idx;
    for (int i = 0; i < NREQ; i++) begin
      if (cool[i] > 0) begin
        cool[i]--;
        if (cool[i] == 0 && auto_rereq) raise(i, AW'($urandom), 16'($urandom));
      end
    end
    RST = rst_v;
    for (int i = 0; i < NREQ; i++) begin
      REQ[i]               = pend[i];
      REQ_ADDR[i*AW +: AW] = paddr[i];
      REQ_DATA[i*16 +: 16] = pdata[i];
    end
    // The write driven during the ending cycle lands regardless of reset.
    for (int a = 0; a < NREG; a++) begin
      if (e_en[a]) mbank[a] = e_d;
    end
    e_gnt = '0;
    e_en  = '0;
    e_d   = '0;
    if (rst_v) begin
      mbusy = 1'b0;
      mptr  = 0;
    end else if (mbusy) begin
      mbusy = 1'b0;
    end else begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (mptr + k) % NREQ;
        if (w < 0 && pend[idx]) w = idx;
      end
      if (w >= 0) begin
        e_gnt[w] = 1'b1;
        if (!(LOCK && paddr[w] == '0)) e_en[paddr[w]] = 1'b1;
        e_d   = pdata[w];
        mbusy = 1'b1;
        mptr  = (w + 1) % NREQ;
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    chk("gnt", GNT, e_gnt);
    chk("reg_en", REG_EN, e_en);
    chk("reg_d", REG_D, e_d);
    chk("busy", BUSY, mbusy);
    chk("gnt_back_to_back", GNT & prev_gnt, '0);
    for (int a = 0; a < NREG; a++) begin
      chk($sformatf("bank%0d", a), bank[a], mbank[a]);
    end
    prev_gnt = GNT;
    for (int i = 0; i < NREQ; i++) begin
      if (e_gnt[i]) begin
        pend[i] = 1'b0;
        cool[i] = 2;
        order.push_back(i);
      end
    end
  endtask

  initial begin
    RST = 1'b1; REQ = '0; REQ_ADDR = '0; REQ_DATA = '0;
    mptr = 0; mbusy = 1'b0; e_gnt = '0; e_en = '0; e_d = '0; prev_gnt = '0;
    auto_rereq = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; paddr[i] = '0; pdata[i] = '0; cool[i] = 0;
    end

    // Reset held two cycles with every requester asserting.
    for (int i = 0; i < NREQ; i++) raise(i, AW'(i + 1), 16'($urandom));
    tick(1'b1);
    chk("rst_gnt", GNT, 3'b000);
    chk("rst_busy", BUSY, 1'b0);
    tick(1'b1);
    chk("rst_reg_en", REG_EN, 8'h00);

    // Fairness: everyone re-requests after its grant.
    auto_rereq = 1'b1;
    order.delete();
    for (int n = 0; n < 8; n++) tick(1'b0);
    chk("rr_count", order.size() >= 4, 1);
    if (order.size() >= 4) begin
      chk("rr_order0", order[0], 0);
      chk("rr_order1", order[1], 1);
      chk("rr_order2", order[2], 2);
      chk("rr_order3", order[3], 0);
    end

    // Drain outstanding requests.
    auto_rereq = 1'b0;
    for (int n = 0; n < 10; n++) tick(1'b0);
    for (int i = 0; i < NREQ; i++) cool[i] = 0;

    // Single write from requester 1.
    raise(1, 3'd5, 16'hBEEF);
    tick(1'b0);
    chk("single_gnt", GNT, 3'b010);
    chk("single_en", REG_EN, 8'h20);
    chk("single_d", REG_D, 16'hBEEF);
    chk("single_busy", BUSY, 1'b1);
    tick(1'b0);
    chk("single_gnt_clr", GNT, 3'b000);
    chk("single_en_clr", REG_EN, 8'h00);
    chk("single_d_clr", REG_D, 16'h0000);
    chk("single_busy_clr", BUSY, 1'b0);

    // Wrap: pointer sits at 2, requesters 0 and 1 ask.
    raise(0, 3'd3, 16'($urandom));
    raise(1, 3'd4, 16'($urandom));
    order.delete();
    for (int n = 0; n < 4; n++) tick(1'b0);
    chk("wrap_count", order.size(), 2);
    if (order.size() == 2) begin
      chk("wrap_first", order[0], 0);
      chk("wrap_second", order[1], 1);
    end

    // Reset during WRITE: requester 1 wins (pointer would move to 2).
    saved = 16'($urandom);
    raise(1, 3'd2, saved);
    tick(1'b0);
    chk("rstw_en", REG_EN, 8'h04);
    tick(1'b1);
    chk("rstw_bank2", bank[2], saved);
    chk("rstw_en_clr", REG_EN, 8'h00);
    chk("rstw_gnt_clr", GNT, 3'b000);
    for (int i = 0; i < NREQ; i++) raise(i, AW'(i + 4), 16'($urandom));
    order.delete();
    tick(1'b0);
    chk("rstw_ptr0", GNT, 3'b001);
    for (int n = 0; n < 6; n++) tick(1'b0);
    for (int i = 0; i < NREQ; i++) cool[i] = 0;

    // Address 0 write (locked or not depending on build).
    raise(2, 3'd0, 16'h1234);
    tick(1'b0);
    chk("zero_gnt", GNT, 3'b100);
    chk("zero_en", REG_EN, LOCK ? 8'h00 : 8'h01);
    chk("zero_busy", BUSY, 1'b1);
    tick(1'b0);

    // Randomised traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && cool[i] == 0 && $urandom_range(0, 9) < 3) begin
          raise(i, AW'($urandom), 16'($urandom));
        end
      end
      tick($urandom_range(0, 49) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
